// File: rtl/ptlrx_bank_sync_if.sv
// Bus bundle for ptlrx_bank_sync: PTL toggle inputs and clear in, and the per-channel toggle, pulse, violation and count results out.
// The PTLRX_VIOLCNT_EN macro adds the viol_cnt bus.
interface ptlrx_bank_sync_if #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8
);
    logic [CHANNELS-1:0]       a;
    logic                      cnt_clr;
    logic [CHANNELS-1:0]       q;
    logic [CHANNELS-1:0]       pulse;
    logic                      ready;
    logic [CHANNELS-1:0]       viol;
    logic [CHANNELS*CNT_W-1:0] cnt;
`ifdef PTLRX_VIOLCNT_EN
    logic [CHANNELS*CNT_W-1:0] viol_cnt;
`endif

    modport master (
        output a, cnt_clr,
`ifdef PTLRX_VIOLCNT_EN
        input  viol_cnt,
`endif
        input  q, pulse, ready, viol, cnt
    );

    modport slave (
        input  a, cnt_clr,
`ifdef PTLRX_VIOLCNT_EN
        output viol_cnt,
`endif
        output q, pulse, ready, viol, cnt
    );
endinterface

// File: rtl/ptlrx_bank_sync.sv
// Multi-channel clocked PTL receiver. Each channel synchronises a toggle input, blanks the warm-up window and enforces a minimum edge separation.
// It counts accepted edges. Optional macro PTLRX_VIOLCNT_EN adds per-channel rejected-edge counters.
module ptlrx_bank_sync #(
    parameter int CHANNELS     = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int LATENCY      = 1,
    parameter int BEGIN_CYCLES = 8,
    parameter int MIN_SEP      = 2,
    parameter int CNT_W        = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    ptlrx_bank_sync_if.slave  bus
);
    localparam int WU_W  = $clog2(BEGIN_CYCLES + 1);
    localparam int SEP_W = (MIN_SEP > 1) ? $clog2(MIN_SEP) : 1;

    logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0] sync_d [SYNC_STAGES];
    logic [CHANNELS-1:0] sp_q, sp_d;
    logic [CHANNELS-1:0] s;
    logic [CHANNELS-1:0] edge_det;
    logic [WU_W-1:0]     wu_q, wu_d;
    logic                ready_q, ready_d;
    logic [CHANNELS-1:0] tog_vec;
    logic [CHANNELS-1:0] pls_vec;

    assign s        = sync_q[SYNC_STAGES-1];
    assign edge_det = s ^ sp_q;

    always_comb begin
        sync_d[0] = bus.a;
        for (int st = 1; st < SYNC_STAGES; st++) begin
            sync_d[st] = sync_q[st-1];
        end
        // sp follows s even while blanked, so a level held at reset release is absorbed.
        sp_d    = s;
        wu_d    = wu_q;
        ready_d = ready_q;
        if (!ready_q) begin
            wu_d = wu_q + 1'b1;
            if (wu_q == WU_W'(BEGIN_CYCLES - 1)) begin
                ready_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int st = 0; st < SYNC_STAGES; st++) begin
                sync_q[st] <= '0;
            end
            sp_q    <= '0;
            wu_q    <= '0;
            ready_q <= 1'b0;
        end else begin
            for (int st = 0; st < SYNC_STAGES; st++) begin
                sync_q[st] <= sync_d[st];
            end
            sp_q    <= sp_d;
            wu_q    <= wu_d;
            ready_q <= ready_d;
        end
    end

    assign bus.ready = ready_q;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [SEP_W-1:0] sep_q, sep_d;
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             viol_q, viol_d;
            logic             tog_q, tog_d;
            logic             pls_q, pls_d;
            logic             accept, reject;
`ifdef PTLRX_VIOLCNT_EN
            logic [CNT_W-1:0] vcnt_q, vcnt_d;
`endif

            assign accept = edge_det[gi] & ready_q & (sep_q == '0);
            assign reject = edge_det[gi] & ready_q & (sep_q != '0);

            always_comb begin
                sep_d  = sep_q;
                cnt_d  = cnt_q;
                viol_d = viol_q;
                tog_d  = tog_q ^ accept;
                pls_d  = accept;
                if (accept) begin
                    sep_d = SEP_W'(MIN_SEP - 1);
                end else if (sep_q != '0) begin
                    sep_d = sep_q - 1'b1;
                end
                // Clear applies first so a coincident accept/reject still lands.
                if (bus.cnt_clr) begin
                    cnt_d  = '0;
                    viol_d = 1'b0;
                end
                if (accept && (cnt_d != '1)) begin
                    cnt_d = cnt_d + 1'b1;
                end
                if (reject) begin
                    viol_d = 1'b1;
                end
`ifdef PTLRX_VIOLCNT_EN
                vcnt_d = bus.cnt_clr ? '0 : vcnt_q;
                if (reject && (vcnt_d != '1)) begin
                    vcnt_d = vcnt_d + 1'b1;
                end
`endif
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sep_q  <= '0;
                    cnt_q  <= '0;
                    viol_q <= 1'b0;
                    tog_q  <= 1'b0;
                    pls_q  <= 1'b0;
`ifdef PTLRX_VIOLCNT_EN
                    vcnt_q <= '0;
`endif
                end else begin
                    sep_q  <= sep_d;
                    cnt_q  <= cnt_d;
                    viol_q <= viol_d;
                    tog_q  <= tog_d;
                    pls_q  <= pls_d;
`ifdef PTLRX_VIOLCNT_EN
                    vcnt_q <= vcnt_d;
`endif
                end
            end

            assign tog_vec[gi]                  = tog_q;
            assign pls_vec[gi]                  = pls_q;
            assign bus.viol[gi]                 = viol_q;
            assign bus.cnt[gi*CNT_W +: CNT_W]   = cnt_q;
`ifdef PTLRX_VIOLCNT_EN
            assign bus.viol_cnt[gi*CNT_W +: CNT_W] = vcnt_q;
`endif
        end

        if (LATENCY == 0) begin : g_nopipe
            assign bus.q     = tog_vec;
            assign bus.pulse = pls_vec;
        end else begin : g_pipe
            logic [CHANNELS-1:0] qp_q [LATENCY];
            logic [CHANNELS-1:0] qp_d [LATENCY];
            logic [CHANNELS-1:0] pp_q [LATENCY];
            logic [CHANNELS-1:0] pp_d [LATENCY];

            always_comb begin
                qp_d[0] = tog_vec;
                pp_d[0] = pls_vec;
                for (int j = 1; j < LATENCY; j++) begin
                    qp_d[j] = qp_q[j-1];
                    pp_d[j] = pp_q[j-1];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int j = 0; j < LATENCY; j++) begin
                        qp_q[j] <= '0;
                        pp_q[j] <= '0;
                    end
                end else begin
                    for (int j = 0; j < LATENCY; j++) begin
                        qp_q[j] <= qp_d[j];
                        pp_q[j] <= pp_d[j];
                    end
                end
            end

            assign bus.q     = qp_q[LATENCY-1];
            assign bus.pulse = pp_q[LATENCY-1];
        end
    endgenerate
endmodule
